// File: rtl/miim_master.sv
// MIIM (MDIO clause-22) management master: serialises one read or write frame
// per request, generating MDC from clk and capturing read data from mdio_i.
module miim_master #(
    parameter int unsigned MDC_DIV = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  miim_phyad,
    input  logic [4:0]  miim_regad,
    input  logic [15:0] miim_wrdata,
    input  logic        miim_wren,
    input  logic        miim_rden,
    output logic        busy,
    output logic [15:0] miim_rddata,
    output logic        miim_rddata_valid,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam int unsigned DIV_W   = 8;
    localparam int unsigned BIT_W   = 6;
    localparam int unsigned FRAME_W = 64;
    localparam int unsigned DATA_W  = 16;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MDC_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_HDR  = BIT_W'(32);
    localparam logic [BIT_W-1:0] BIT_TA   = BIT_W'(46);
    localparam logic [BIT_W-1:0] BIT_DATA = BIT_W'(48);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(63);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_TA,
        S_DATA
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d, next_bit;
    logic [FRAME_W-1:0]   sr_q, sr_d, frame;
    logic                 rd_q, rd_d;
    logic                 busy_d, mdc_d, mdio_o_d, mdio_oe_d, valid_d;
    logic [DATA_W-1:0]    rddata_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sr_d      = sr_q;
        rd_d      = rd_q;
        busy_d    = busy;
        mdc_d     = mdc;
        mdio_o_d  = mdio_o;
        mdio_oe_d = mdio_oe;
        rddata_d  = miim_rddata;
        valid_d   = 1'b0;
        next_bit  = bit_q + BIT_W'(1);
        // Write wins when both strobes are seen together
        frame     = {32'hFFFF_FFFF, 2'b01, (miim_wren ? 2'b01 : 2'b10),
                     miim_phyad, miim_regad, 2'b10,
                     (miim_wren ? miim_wrdata : 16'hFFFF)};

        case (state_q)
            S_IDLE: begin
                if (miim_wren || miim_rden) begin
                    state_d   = S_PREAMBLE;
                    rd_d      = ~miim_wren;
                    div_d     = '0;
                    bit_d     = '0;
                    busy_d    = 1'b1;
                    mdc_d     = 1'b0;
                    mdio_oe_d = 1'b1;
                    mdio_o_d  = frame[FRAME_W-1];
                    sr_d      = {frame[FRAME_W-2:0], 1'b0};
                end
            end
            default: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    mdc_d = ~mdc;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                // Bit boundary: last cycle of the mdc-high half, mdio_i sampled here
                if (div_q == DIV_LAST && mdc) begin
                    if (bit_q == BIT_LAST) begin
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                        mdio_o_d  = 1'b1;
                        mdio_oe_d = 1'b0;
                        bit_d     = '0;
                        if (rd_q) begin
                            rddata_d = {sr_q[DATA_W-2:0], mdio_i};
                            valid_d  = 1'b1;
                        end
                    end else begin
                        bit_d     = next_bit;
                        mdio_o_d  = sr_q[FRAME_W-1];
                        sr_d      = {sr_q[FRAME_W-2:0], mdio_i};
                        mdio_oe_d = ~(rd_q && (next_bit >= BIT_TA));
                        if (next_bit == BIT_HDR)  state_d = S_HEADER;
                        if (next_bit == BIT_TA)   state_d = S_TA;
                        if (next_bit == BIT_DATA) state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q           <= S_IDLE;
            div_q             <= '0;
            bit_q             <= '0;
            sr_q              <= '0;
            rd_q              <= 1'b0;
            busy              <= 1'b0;
            mdc               <= 1'b0;
            mdio_o            <= 1'b1;
            mdio_oe           <= 1'b0;
            miim_rddata       <= '0;
            miim_rddata_valid <= 1'b0;
        end else begin
            state_q           <= state_d;
            div_q             <= div_d;
            bit_q             <= bit_d;
            sr_q              <= sr_d;
            rd_q              <= rd_d;
            busy              <= busy_d;
            mdc               <= mdc_d;
            mdio_o            <= mdio_o_d;
            mdio_oe           <= mdio_oe_d;
            miim_rddata       <= rddata_d;
            miim_rddata_valid <= valid_d;
        end
    end

endmodule

// File: doc/miim_master.md
MIIM_MASTER -- requirements
Module: miim_master

Interface
REQ-001 Parameter MDC_DIV, default 20, clk cycles per MDC half-period; legal range 2..255.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rstn  in  1  reset; synchronous, active-low.
REQ-004 miim_phyad  in  5  PHY address of request.
REQ-005 miim_regad  in  5  register address of request.
REQ-006 miim_wrdata  in  16  write data of request.
REQ-007 miim_wren  in  1  write request strobe; one-cycle pulse.
REQ-008 miim_rden  in  1  read request strobe; one-cycle pulse.
REQ-009 busy  out  1  frame in progress; requests ignored while high.
REQ-010 miim_rddata  out  16  last completed read data.
REQ-011 miim_rddata_valid  out  1  one-cycle pulse when miim_rddata is updated.
REQ-012 mdc  out  1  management clock to PHY.
REQ-013 mdio_o  out  1  MDIO output value.
REQ-014 mdio_oe  out  1  MDIO output enable; 1 means drive mdio_o.
REQ-015 mdio_i  in  1  MDIO input from pad.

Function
REQ-016 Accept: the block SHALL accept a request on a clk edge where busy=0 and (miim_wren or miim_rden)=1, latching phyad, regad, wrdata and op; it SHALL ignore later input changes until the frame ends.
REQ-017 Simultaneous miim_wren and miim_rden: the block SHALL execute a write.
REQ-018 Requests with busy=1: the block SHALL drop them without effect or queueing.
REQ-019 States: IDLE, PREAMBLE (32 bits), HEADER (14 bits: ST=01, OP=01 write/10 read, PHYAD, REGAD, MSB first), TA (2 bits), DATA (16 bits, MSB first); DATA returns to IDLE.
REQ-020 Bit timing: each of the 64 bits lasts 2*MDC_DIV clk cycles: mdc=0 for the first MDC_DIV cycles, mdc=1 for the last MDC_DIV cycles; mdio_o changes only on the cycle mdc goes 0.
REQ-021 Busy timing: for a request accepted at edge A, busy=1 from A+1 through A+128*MDC_DIV; busy=0 and state IDLE at A+1+128*MDC_DIV.
REQ-022 Write frame: mdio_oe=1 for all 64 bits; TA bits = 1,0; DATA = latched wrdata.
REQ-023 Read frame: mdio_oe=1 for bits 0..45, mdio_oe=0 for bits 46..63 (TA and DATA).
REQ-024 Read sampling: for each DATA bit, the block SHALL sample mdio_i on the last clk cycle of the mdc=1 half and shift it in MSB first; TA input is not checked.
REQ-025 Read completion: miim_rddata SHALL update and miim_rddata_valid SHALL pulse high for one cycle on the same edge busy falls; write frames SHALL NOT pulse miim_rddata_valid.
REQ-026 miim_rddata SHALL hold its value between reads.
REQ-027 Idle outputs: mdc=0, mdio_o=1, mdio_oe=0, busy=0.
REQ-028 Back-to-back: a request presented on the edge where busy=0 first SHALL be accepted, and its preamble SHALL begin the next cycle with no extra idle bit.
REQ-029 Counters: MDC divider counter width 8 bits, wraps at MDC_DIV-1; bit counter 6 bits, 0..63, no wrap beyond 63.

Reset
REQ-030 With rstn=0 at a clk edge, the block SHALL force IDLE, busy=0, mdc=0, mdio_o=1, mdio_oe=0, miim_rddata=16'h0000, miim_rddata_valid=0, and clear all counters.
REQ-031 Reset mid-frame SHALL abort the frame with no miim_rddata update and no valid pulse; the first request after rstn returns high SHALL start a complete frame.

Verification
REQ-032 MDC_DIV=2, write phyad=0, regad=0, wrdata=16'h0044 -> mdio bit stream = 32 ones, 0101 00000 00000 10 0000000001000100 sampled at mdc rising edges; busy high for exactly 256 cycles; mdio_oe=1 throughout.
REQ-033 MDC_DIV=2, read phyad=0, regad=2, PHY model drives 16'h0283 in DATA -> header 0110 00000 00010, mdio_oe=0 from bit 46, miim_rddata=16'h0283 with one valid pulse coincident with busy fall.
REQ-034 miim_wren and miim_rden high together, wrdata=16'hA5A5 -> write frame (OP=01), no valid pulse.
REQ-035 Second miim_rden pulse 10 cycles after accept -> ignored; only one frame; busy timing unchanged.
REQ-036 rstn low at bit 50 of a read -> next edge all outputs at reset values, miim_rddata stays 16'h0000; new write after release produces full 64-bit frame.
REQ-037 miim_wren on the edge busy falls after a read -> accepted; new preamble starts the next cycle, busy low for exactly one cycle.
